// File: rtl/flopenr_pipe.sv
// Elastic enabled-register pipeline: DEPTH valid/ready stages with bubble collapse and registered occupancy.
// Optional synchronous flush port is built only when FLOPENR_PIPE_FLUSH_EN is defined.
module flopenr_pipe #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
`ifdef FLOPENR_PIPE_FLUSH_EN
   input  logic                       flush,
`endif
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [OCC_W-1:0] r_occ;

   logic [DEPTH-1:0] w_ready;
   logic             w_flush;
   logic             w_accept;
   logic             w_deliver;

`ifdef FLOPENR_PIPE_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   // A stage can load when it is empty or the stage ahead of it is loading too.
   always_comb begin : readyChain
      logic rdy;
      rdy     = out_ready;
      w_ready = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy        = !r_valid[i] || rdy;
         w_ready[i] = rdy;
      end
   end

   assign in_ready  = w_ready[0] && !reset && !w_flush;
   assign w_accept  = in_valid && in_ready;
   assign w_deliver = r_valid[DEPTH-1] && out_ready;

   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_valid <= '0;
         r_occ   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= RESET_VAL;
         end
      end else begin
         // Data only moves with a valid word, so bubbles leave old contents in place.
         if (w_ready[0]) begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
               r_data[0] <= in_data;
            end
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (w_ready[i]) begin
               r_valid[i] <= r_valid[i-1];
               if (r_valid[i-1]) begin
                  r_data[i] <= r_data[i-1];
               end
            end
         end
         if (w_accept && !w_deliver) begin
            r_occ <= r_occ + OCC_W'(1);
         end else if (w_deliver && !w_accept) begin
            r_occ <= r_occ - OCC_W'(1);
         end
      end
   end

   assign out_valid = r_valid[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign occupancy = r_occ;

endmodule

// File: tb/tb_flopenr_pipe.sv
// Bench for flopenr_pipe: three depths share one stimulus stream and are checked against a
// timestamp/queue model (a word is visible at max(accept+DEPTH, previous delivery+1)).
module tb_flopenr_pipe;

   localparam int         NDUT = 3;
   localparam logic [7:0] RV   = 8'hA5;

   logic       clk = 1'b0;
   logic       reset;
   logic       inValid;
   logic       outReady;
   logic       flushSig;
   logic [7:0] inData;

   logic       inReady0, inReady1, inReady2;
   logic       outValid0, outValid1, outValid2;
   logic [7:0] outData0, outData1, outData2;
   logic [1:0] occ0;
   logic [2:0] occ1;
   logic [1:0] occ2;

   logic       dInReady  [NDUT];
   logic       dOutValid [NDUT];
   logic [7:0] dOutData  [NDUT];
   logic [2:0] dOcc      [NDUT];

   logic [7:0] mData        [NDUT][8];
   int         mEarliest    [NDUT][8];
   int         mHead        [NDUT];
   int         mCount       [NDUT];
   int         mLastDeliver [NDUT];
   logic [7:0] mLastData    [NDUT];
   int         cyc;
   int         nChecks;
   int         nPass;

   always #5 clk = ~clk;

   flopenr_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV)) dut0 (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady0), .in_data(inData),
      .out_valid(outValid0), .out_ready(outReady), .out_data(outData0),
`ifdef FLOPENR_PIPE_FLUSH_EN
      .flush(flushSig),
`endif
      .occupancy(occ0));

   flopenr_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) dut1 (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady1), .in_data(inData),
      .out_valid(outValid1), .out_ready(outReady), .out_data(outData1),
`ifdef FLOPENR_PIPE_FLUSH_EN
      .flush(flushSig),
`endif
      .occupancy(occ1));

   flopenr_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VAL(RV)) dut2 (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady2), .in_data(inData),
      .out_valid(outValid2), .out_ready(outReady), .out_data(outData2),
`ifdef FLOPENR_PIPE_FLUSH_EN
      .flush(flushSig),
`endif
      .occupancy(occ2));

   assign dInReady[0]  = inReady0;
   assign dInReady[1]  = inReady1;
   assign dInReady[2]  = inReady2;
   assign dOutValid[0] = outValid0;
   assign dOutValid[1] = outValid1;
   assign dOutValid[2] = outValid2;
   assign dOutData[0]  = outData0;
   assign dOutData[1]  = outData1;
   assign dOutData[2]  = outData2;
   assign dOcc[0]      = {1'b0, occ0};
   assign dOcc[1]      = occ1;
   assign dOcc[2]      = {1'b0, occ2};

   function automatic int depthOf(int k);
      case (k)
         0:       return 3;
         1:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int headAvail(int k);
      int a;
      a = mEarliest[k][mHead[k]];
      if (mLastDeliver[k] + 1 > a) a = mLastDeliver[k] + 1;
      return a;
   endfunction

   function automatic logic modelOutValid(int k);
      return (mCount[k] > 0) && (headAvail(k) <= cyc);
   endfunction

   function automatic logic [7:0] modelOutData(int k);
      return modelOutValid(k) ? mData[k][mHead[k]] : mLastData[k];
   endfunction

   function automatic logic modelInReady(int k);
      return !reset && !flushSig && ((mCount[k] < depthOf(k)) || outReady);
   endfunction

   task automatic modelClear(int k);
      mHead[k]        = 0;
      mCount[k]       = 0;
      mLastDeliver[k] = -100;
      mLastData[k]    = RV;
   endtask

   // Apply this cycle's handshakes to the model, then move to just after the next rising edge.
   task automatic advance();
      for (int k = 0; k < NDUT; k++) begin
         logic acc;
         logic dlv;
         int   slot;
         acc = inValid && modelInReady(k);
         dlv = modelOutValid(k) && outReady;
         if (reset || flushSig) begin
            modelClear(k);
         end else begin
            if (dlv) begin
               mLastData[k]    = mData[k][mHead[k]];
               mHead[k]        = (mHead[k] + 1) % 8;
               mCount[k]       = mCount[k] - 1;
               mLastDeliver[k] = cyc;
            end
            if (acc) begin
               slot               = (mHead[k] + mCount[k]) % 8;
               mData[k][slot]     = inData;
               mEarliest[k][slot] = cyc + depthOf(k);
               mCount[k]          = mCount[k] + 1;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic applyReset(int n);
      reset    = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b0;
      repeat (n) begin
         @(negedge clk);
         advance();
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      inValid  = 1'b1;
      inData   = 8'($urandom);
      outReady = 1'b1;
      repeat (2) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            nChecks++;
            if (dOutValid[k] !== 1'b0) $display("[TB] FAIL reset_out_valid dut%0d: got %b expected 0", k, dOutValid[k]);
            else nPass++;
            nChecks++;
            if (dOutData[k] !== RV) $display("[TB] FAIL reset_out_data dut%0d: got %h expected %h", k, dOutData[k], RV);
            else nPass++;
            nChecks++;
            if (dOcc[k] !== 3'd0) $display("[TB] FAIL reset_occupancy dut%0d: got %0d expected 0", k, dOcc[k]);
            else nPass++;
            nChecks++;
            if (dInReady[k] !== 1'b0) $display("[TB] FAIL reset_in_ready dut%0d: got %b expected 0", k, dInReady[k]);
            else nPass++;
         end
         advance();
      end
      reset   = 1'b0;
      inValid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         nChecks++;
         if (dInReady[k] !== 1'b1) $display("[TB] FAIL post_reset_in_ready dut%0d: got %b expected 1", k, dInReady[k]);
         else nPass++;
         nChecks++;
         if (dOutValid[k] !== 1'b0) $display("[TB] FAIL post_reset_out_valid dut%0d: got %b expected 0", k, dOutValid[k]);
         else nPass++;
      end
      advance();
   endtask

   task automatic test_streaming();
      logic [2:0] peak;
      logic       expValid;
      peak = 3'd0;
      applyReset(1);
      outReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         inValid  = (i < 5);
         inData   = 8'(i + 1);
         expValid = (i >= 3) && (i <= 7);
         @(negedge clk);
         if (i < 5) begin
            nChecks++;
            if (dInReady[0] !== 1'b1) $display("[TB] FAIL stream_in_ready cycle%0d: got %b expected 1", i, dInReady[0]);
            else nPass++;
         end
         nChecks++;
         if (dOutValid[0] !== expValid) $display("[TB] FAIL stream_out_valid cycle%0d: got %b expected %b", i, dOutValid[0], expValid);
         else nPass++;
         if (expValid) begin
            nChecks++;
            if (dOutData[0] !== 8'(i - 2)) $display("[TB] FAIL stream_out_data cycle%0d: got %0d expected %0d", i, dOutData[0], i - 2);
            else nPass++;
         end
         if (dOcc[0] > peak) peak = dOcc[0];
         advance();
      end
      nChecks++;
      if (peak !== 3'd3) $display("[TB] FAIL stream_peak_occupancy: got %0d expected 3", peak);
      else nPass++;
   endtask

   task automatic test_backpressure();
      logic [7:0] got[$];
      applyReset(1);
      outReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         inValid = 1'b1;
         inData  = 8'(10 + i);
         @(negedge clk);
         nChecks++;
         if (dInReady[0] !== (i < 3)) $display("[TB] FAIL bp_in_ready word%0d: got %b expected %b", 10 + i, dInReady[0], (i < 3));
         else nPass++;
         if (i == 3) begin
            nChecks++;
            if (dOcc[0] !== 3'd3) $display("[TB] FAIL bp_occupancy: got %0d expected 3", dOcc[0]);
            else nPass++;
         end
         advance();
      end
      outReady = 1'b1;
      inData   = 8'd13;
      @(negedge clk);
      nChecks++;
      if (dInReady[0] !== 1'b1) $display("[TB] FAIL bp_release_in_ready: got %b expected 1", dInReady[0]);
      else nPass++;
      if (dOutValid[0]) got.push_back(dOutData[0]);
      advance();
      inValid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (dOutValid[0]) got.push_back(dOutData[0]);
         advance();
      end
      nChecks++;
      if (got.size() != 4) $display("[TB] FAIL bp_delivered_count: got %0d expected 4", got.size());
      else nPass++;
      for (int j = 0; j < got.size() && j < 4; j++) begin
         nChecks++;
         if (got[j] !== 8'(10 + j)) $display("[TB] FAIL bp_order idx%0d: got %0d expected %0d", j, got[j], 10 + j);
         else nPass++;
      end
   endtask

   task automatic test_bubble();
      logic [7:0] got[$];
      int         gotCyc[$];
      applyReset(1);
      outReady = 1'b0;
      for (int i = 0; i < 7; i++) begin
         inValid = (i == 0) || (i == 3);
         inData  = (i == 0) ? 8'd7 : 8'd8;
         @(negedge clk);
         if (i == 6) begin
            nChecks++;
            if (dOcc[1] !== 3'd2) $display("[TB] FAIL bubble_occupancy: got %0d expected 2", dOcc[1]);
            else nPass++;
            nChecks++;
            if (dOutValid[1] !== 1'b1 || dOutData[1] !== 8'd7) $display("[TB] FAIL bubble_head: got v=%b d=%0d expected v=1 d=7", dOutValid[1], dOutData[1]);
            else nPass++;
         end
         advance();
      end
      outReady = 1'b1;
      inValid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (dOutValid[1]) begin
            got.push_back(dOutData[1]);
            gotCyc.push_back(i);
         end
         advance();
      end
      nChecks++;
      if (got.size() != 2) $display("[TB] FAIL bubble_count: got %0d expected 2", got.size());
      else nPass++;
      if (got.size() == 2) begin
         nChecks++;
         if (got[0] !== 8'd7 || got[1] !== 8'd8) $display("[TB] FAIL bubble_order: got %0d,%0d expected 7,8", got[0], got[1]);
         else nPass++;
         nChecks++;
         if (gotCyc[1] - gotCyc[0] != 1) $display("[TB] FAIL bubble_gap: got %0d cycles expected 1", gotCyc[1] - gotCyc[0]);
         else nPass++;
      end
   endtask

   task automatic test_full_simul();
      logic [7:0] got[$];
      applyReset(1);
      outReady = 1'b0;
      for (int i = 0; i < 2; i++) begin
         inValid = 1'b1;
         inData  = 8'(20 + i);
         @(negedge clk);
         advance();
      end
      inValid = 1'b0;
      @(negedge clk);
      nChecks++;
      if (dOcc[2] !== 3'd2 || dInReady[2] !== 1'b0) $display("[TB] FAIL full_stall: got occ=%0d rdy=%b expected occ=2 rdy=0", dOcc[2], dInReady[2]);
      else nPass++;
      advance();
      outReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         inValid = 1'b1;
         inData  = 8'(22 + i);
         @(negedge clk);
         nChecks++;
         if (dOcc[2] !== 3'd2) $display("[TB] FAIL full_simul_occupancy cycle%0d: got %0d expected 2", i, dOcc[2]);
         else nPass++;
         nChecks++;
         if (dInReady[2] !== 1'b1) $display("[TB] FAIL full_simul_in_ready cycle%0d: got %b expected 1", i, dInReady[2]);
         else nPass++;
         if (dOutValid[2]) got.push_back(dOutData[2]);
         advance();
      end
      inValid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (dOutValid[2]) got.push_back(dOutData[2]);
         advance();
      end
      nChecks++;
      if (got.size() != 8) $display("[TB] FAIL full_simul_count: got %0d expected 8", got.size());
      else nPass++;
      for (int j = 0; j < got.size() && j < 8; j++) begin
         nChecks++;
         if (got[j] !== 8'(20 + j)) $display("[TB] FAIL full_simul_order idx%0d: got %0d expected %0d", j, got[j], 20 + j);
         else nPass++;
      end
   endtask

`ifdef FLOPENR_PIPE_FLUSH_EN
   task automatic test_flush();
      applyReset(1);
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inValid = 1'b1;
         inData  = 8'(8'h30 + i);
         @(negedge clk);
         advance();
      end
      inData   = 8'h33;
      flushSig = 1'b1;
      @(negedge clk);
      nChecks++;
      if (dInReady[0] !== 1'b0) $display("[TB] FAIL flush_in_ready: got %b expected 0", dInReady[0]);
      else nPass++;
      nChecks++;
      if (dOcc[0] !== 3'd3) $display("[TB] FAIL flush_pre_occupancy: got %0d expected 3", dOcc[0]);
      else nPass++;
      nChecks++;
      if (dOutValid[0] !== 1'b1 || dOutData[0] !== 8'h30) $display("[TB] FAIL flush_head: got v=%b d=%h expected v=1 d=30", dOutValid[0], dOutData[0]);
      else nPass++;
      advance();
      flushSig = 1'b0;
      inValid  = 1'b0;
      @(negedge clk);
      nChecks++;
      if (dOcc[0] !== 3'd0 || dOutData[0] !== RV) $display("[TB] FAIL flush_cleared: got occ=%0d d=%h expected occ=0 d=%h", dOcc[0], dOutData[0], RV);
      else nPass++;
      nChecks++;
      if (dInReady[0] !== 1'b1) $display("[TB] FAIL flush_after_in_ready: got %b expected 1", dInReady[0]);
      else nPass++;
      for (int i = 0; i < 4; i++) begin
         nChecks++;
         if (dOutValid[0] !== 1'b0) $display("[TB] FAIL flush_leftover cycle%0d: got %b expected 0", i, dOutValid[0]);
         else nPass++;
         advance();
         @(negedge clk);
      end
      advance();
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         reset    = ($urandom_range(63) == 0);
         inValid  = ($urandom_range(9) < 7);
         outReady = ($urandom_range(9) < 6);
         inData   = 8'($urandom);
`ifdef FLOPENR_PIPE_FLUSH_EN
         flushSig = ($urandom_range(49) == 0);
`endif
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            nChecks++;
            if (dOutValid[k] !== modelOutValid(k)) $display("[TB] FAIL rand_out_valid dut%0d cyc%0d: got %b expected %b", k, cyc, dOutValid[k], modelOutValid(k));
            else nPass++;
            nChecks++;
            if (dOutData[k] !== modelOutData(k)) $display("[TB] FAIL rand_out_data dut%0d cyc%0d: got %h expected %h", k, cyc, dOutData[k], modelOutData(k));
            else nPass++;
            nChecks++;
            if (dOcc[k] !== 3'(mCount[k])) $display("[TB] FAIL rand_occupancy dut%0d cyc%0d: got %0d expected %0d", k, cyc, dOcc[k], mCount[k]);
            else nPass++;
            nChecks++;
            if (dInReady[k] !== modelInReady(k)) $display("[TB] FAIL rand_in_ready dut%0d cyc%0d: got %b expected %b", k, cyc, dInReady[k], modelInReady(k));
            else nPass++;
         end
         advance();
      end
      reset    = 1'b0;
      flushSig = 1'b0;
   endtask

   // Directed scenarios first, then a long randomized run against the model.
   initial begin
      reset    = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b0;
      inData   = 8'd0;
      flushSig = 1'b0;
      nChecks  = 0;
      nPass    = 0;
      cyc      = 0;
      for (int k = 0; k < NDUT; k++) modelClear(k);
      @(posedge clk);
      #1;
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_full_simul();
`ifdef FLOPENR_PIPE_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
